// File: rtl/i3c_ahb_pkg.sv
// Shared AHB-Lite constants and the manager FSM state type for the I3C core's bus initiators.
package i3c_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } ahb_mgr_state_e;

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-strobe generator: strobes for a (size, low address) pair plus a legal/aligned flag.
module ahb_strb_gen #(
  parameter  int unsigned DATA_WIDTH = 64,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned LW         = $clog2(NB)
) (
  input  logic [2:0]    size,
  input  logic [LW-1:0] addr_lo,
  output logic [NB-1:0] strb,
  output logic          ok
);

  logic [31:0] nbytes;

  // Strobes are built per lane so a full-bus size never overflows an NB-bit shift.
  always_comb begin
    nbytes = 32'd1 << size;
    ok     = (32'(size) <= LW) && ((32'(addr_lo) & (nbytes - 32'd1)) == 32'd0);
    strb   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      strb[i] = ok && (i >= 32'(addr_lo)) && (i < 32'(addr_lo) + nbytes);
    end
  end

endmodule

// File: rtl/i3c_ahb_manager.sv
// AHB-Lite single-transfer manager for internal I3C agents; one transfer outstanding.
// Optional wait-state timeout is enabled with macro I3C_AHB_MANAGER_TIMEOUT_EN.
module i3c_ahb_manager
  import i3c_ahb_pkg::*;
#(
  parameter int unsigned AHB_DATA_WIDTH  = 64,
  parameter int unsigned AHB_ADDR_WIDTH  = 32,
  parameter int unsigned AHB_BURST_WIDTH = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_write_i,
  input  logic [AHB_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [2:0]                  req_size_i,
  input  logic [AHB_DATA_WIDTH-1:0]   req_wdata_i,
  output logic                        rsp_valid_o,
  output logic [AHB_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        rsp_timeout_o,
  output logic [AHB_ADDR_WIDTH-1:0]   haddr_o,
  output logic [AHB_BURST_WIDTH-1:0]  hburst_o,
  output logic [3:0]                  hprot_o,
  output logic [2:0]                  hsize_o,
  output logic [1:0]                  htrans_o,
  output logic                        hwrite_o,
  output logic [AHB_DATA_WIDTH-1:0]   hwdata_o,
  output logic [AHB_DATA_WIDTH/8-1:0] hwstrb_o,
  input  logic [AHB_DATA_WIDTH-1:0]   hrdata_i,
  input  logic                        hready_i,
  input  logic                        hresp_i
);

  localparam int unsigned NB = AHB_DATA_WIDTH / 8;
  localparam int unsigned LW = $clog2(NB);

  ahb_mgr_state_e state_q, state_d;
  logic           accept;
  logic [NB-1:0]  req_strb;
  logic           req_ok;
  logic           done, done_err, capture;

  ahb_strb_gen #(.DATA_WIDTH(AHB_DATA_WIDTH)) u_strb_gen (
    .size    (req_size_i),
    .addr_lo (req_addr_i[LW-1:0]),
    .strb    (req_strb),
    .ok      (req_ok)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign htrans_o    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hburst_o    = AHB_BURST_WIDTH'(HBURST_SINGLE);
  assign hprot_o     = HPROT_DEFAULT;

`ifdef I3C_AHB_MANAGER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt;
  logic          done_to, rsp_timeout_q;
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    done_err = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_ok) begin
            state_d = ST_ADDR;
          end else begin
            done     = 1'b1;
            done_err = 1'b1;
          end
        end
      end
      ST_ADDR: if (hready_i) state_d = ST_DATA;
      ST_DATA: begin
        if (hready_i) begin
          state_d  = ST_IDLE;
          done     = 1'b1;
          done_err = hresp_i;
          capture  = !hresp_i && !hwrite_o;
        end else if (hresp_i) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        if (hready_i) begin
          state_d  = ST_IDLE;
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef I3C_AHB_MANAGER_TIMEOUT_EN
    done_to = 1'b0;
    // The stall that would make the count reach TIMEOUT_CYCLES ends the transfer.
    if (state_q != ST_IDLE && !hready_i && to_cnt == TO_LAST) begin
      state_d  = ST_IDLE;
      done     = 1'b1;
      done_err = 1'b1;
      done_to  = 1'b1;
      capture  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      haddr_o     <= '0;
      hsize_o     <= '0;
      hwrite_o    <= 1'b0;
      hwdata_o    <= '0;
      hwstrb_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_o <= done;
      rsp_err_o   <= done_err;
      if (capture) rsp_rdata_o <= hrdata_i;
      if (accept) begin
        haddr_o  <= req_addr_i;
        hsize_o  <= req_size_i;
        hwrite_o <= req_write_i;
        hwdata_o <= req_wdata_i;
        hwstrb_o <= req_write_i ? req_strb : '0;
      end
    end
  end

`ifdef I3C_AHB_MANAGER_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt        <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_timeout_q <= done_to;
      if (accept && req_ok) to_cnt <= '0;
      else if (state_q != ST_IDLE) to_cnt <= hready_i ? '0 : to_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_i3c_ahb_manager.sv
// Self-checking bench for i3c_ahb_manager: directed cases then randomized transfers vs. a cycle-count model.
module tb_i3c_ahb_manager;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i;
  logic [2:0]  req_size_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [63:0] rsp_rdata_o;
  logic [31:0] haddr_o;
  logic [2:0]  hburst_o, hsize_o;
  logic [3:0]  hprot_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [63:0] hwdata_o, hrdata_i;
  logic [7:0]  hwstrb_o;
  logic        hready_i, hresp_i;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_rdata = '0;

`ifdef I3C_AHB_MANAGER_TIMEOUT_EN
  localparam int MAXW = 2;
`else
  localparam int MAXW = 8;
`endif

  i3c_ahb_manager #(
    .AHB_DATA_WIDTH (64),
    .AHB_ADDR_WIDTH (32),
    .AHB_BURST_WIDTH(3),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .haddr_o(haddr_o), .hburst_o(hburst_o), .hprot_o(hprot_o), .hsize_o(hsize_o),
    .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hwdata_o(hwdata_o), .hwstrb_o(hwstrb_o),
    .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ek: 0 = OKAY, 1 = two-cycle ERROR (0/1 then 1/1), 2 = ERROR seen directly as 1/1.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input int aw, input int dw, input int ek);
    bit          legal, in_addr, in_data;
    logic [7:0]  strb;
    logic [63:0] exp_rd;
    int          ds, rsp_cyc, d;
    legal   = (size <= 3'd3) && ((addr % (32'd1 << size)) == 32'd0);
    strb    = (legal && wr) ? 8'(((64'd1 << (32'd1 << size)) - 64'd1) << addr[2:0]) : 8'h00;
    ds      = 2 + aw;
    rsp_cyc = !legal ? 1 : (ek == 1) ? ds + dw + 2 : ds + dw + 1;
    exp_rd  = (legal && !wr && ek == 0) ? rdata : last_rdata;

    chk("req_ready_idle", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr;
    req_size_i  = size; req_wdata_i = wdata;
    hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = {$urandom, $urandom};
    for (int c = 1; c <= rsp_cyc; c++) begin
      step();
      req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = {$urandom, $urandom};
      req_write_i = ~wr; req_size_i = 3'($urandom_range(0, 7));
      in_addr = legal && c < ds;
      in_data = legal && c >= ds && c < rsp_cyc;
      d = c - ds;
      hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = {$urandom, $urandom};
      if (in_addr) hready_i = (c == ds - 1);
      else if (in_data) begin
        case (ek)
          0: begin hready_i = (d == dw); if (d == dw) hrdata_i = rdata; end
          1: begin hready_i = (d == dw + 1); hresp_i = (d >= dw); end
          default: begin hready_i = (d == dw); hresp_i = (d == dw); end
        endcase
      end
      chk("htrans", 64'(htrans_o), in_addr ? 64'h2 : 64'h0);
      chk("rsp_valid", 64'(rsp_valid_o), 64'(c == rsp_cyc));
      if (in_addr) begin
        chk("haddr", 64'(haddr_o), 64'(addr));
        chk("hsize", 64'(hsize_o), 64'(size));
        chk("hwrite", 64'(hwrite_o), 64'(wr));
        chk("hwstrb", 64'(hwstrb_o), 64'(strb));
      end
      if (in_data && wr) chk("hwdata", hwdata_o, wdata);
    end
    chk("rsp_err", 64'(rsp_err_o), 64'(!legal || ek != 0));
    chk("rsp_rdata", rsp_rdata_o, exp_rd);
    chk("rsp_timeout", 64'(rsp_timeout_o), 64'd0);
    chk("req_ready_done", 64'(req_ready_o), 64'd1);
    last_rdata = exp_rd;
  endtask

  initial begin
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [2:0]  lo;

    rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_size_i = '0; req_wdata_i = '0; hrdata_i = '0; hready_i = 1'b1; hresp_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("rst_htrans", 64'(htrans_o), 64'h0);
    chk("rst_haddr", 64'(haddr_o), 64'h0);
    chk("rst_hsize", 64'(hsize_o), 64'h0);
    chk("rst_hwrite", 64'(hwrite_o), 64'h0);
    chk("rst_hwdata", hwdata_o, 64'h0);
    chk("rst_hwstrb", 64'(hwstrb_o), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    chk("rst_rsp_err", 64'(rsp_err_o), 64'h0);
    chk("rst_rsp_timeout", 64'(rsp_timeout_o), 64'h0);
    chk("rst_rsp_rdata", rsp_rdata_o, 64'h0);
    chk("rst_req_ready", 64'(req_ready_o), 64'h1);
    chk("hburst", 64'(hburst_o), 64'h0);
    chk("hprot", 64'(hprot_o), 64'h3);

    do_txn(1'b1, 32'h100, 3'd3, 64'h1122334455667788, 64'h0, 0, 0, 0);
    do_txn(1'b0, 32'h204, 3'd2, 64'h0, 64'hDEADBEEF_00000000, 0, 2, 0);
    do_txn(1'b0, 32'h8, 3'd3, 64'h0, 64'h0, 0, 0, 1);
    do_txn(1'b0, 32'h3, 3'd1, 64'h0, 64'h0, 0, 0, 0);
    do_txn(1'b1, 32'h40, 3'd4, 64'h0, 64'h0, 0, 0, 0);
    do_txn(1'b1, 32'h107, 3'd0, 64'hAB00000000000000, 64'h0, 1, 1, 0);
    do_txn(1'b0, 32'h10, 3'd3, 64'h0, 64'h0, 0, 1, 2);

    // Reset during the data phase: transfer abandoned without a response.
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h40; req_size_i = 3'd3;
    hready_i = 1'b1; hresp_i = 1'b0;
    step();
    req_valid_i = 1'b0;
    chk("rstmid_nonseq", 64'(htrans_o), 64'h2);
    step();
    hready_i = 1'b0; rst_i = 1'b1;
    step();
    rst_i = 1'b0; hready_i = 1'b1;
    last_rdata = '0;
    chk("rstmid_htrans", 64'(htrans_o), 64'h0);
    chk("rstmid_ready", 64'(req_ready_o), 64'h1);
    chk("rstmid_haddr", 64'(haddr_o), 64'h0);
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_no_rsp", 64'(rsp_valid_o), 64'h0);
      step();
    end
    do_txn(1'b0, 32'h48, 3'd3, 64'h0, 64'h0123456789ABCDEF, 0, 0, 0);

`ifdef I3C_AHB_MANAGER_TIMEOUT_EN
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h10; req_size_i = 3'd2;
    hready_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      req_valid_i = 1'b0; hready_i = 1'b0;
      chk("to_htrans", 64'(htrans_o), (c <= 4) ? 64'h2 : 64'h0);
      chk("to_rsp_valid", 64'(rsp_valid_o), 64'(c == 5));
    end
    hready_i = 1'b1;
    chk("to_rsp_err", 64'(rsp_err_o), 64'h1);
    chk("to_rsp_timeout", 64'(rsp_timeout_o), 64'h1);
    chk("to_ready", 64'(req_ready_o), 64'h1);
    step();
    chk("to_pulse", 64'(rsp_valid_o), 64'h0);
`else
    do_txn(1'b0, 32'h18, 3'd3, 64'h0, 64'h5555AAAA5555AAAA, 3, 12, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom);
      size = 3'($urandom_range(0, 4));
      lo   = 3'($urandom) & ~3'((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 4) == 0) lo = 3'($urandom);
      addr = ($urandom & 32'h0000_FFF8) | 32'(lo);
      do_txn(wr, addr, size, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, MAXW)), int'($urandom_range(0, MAXW)),
             int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) == 0) begin
        step();
        chk("rsp_one_cycle", 64'(rsp_valid_o), 64'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
